alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal: 8, 16, 32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port res  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port Lbus  input  WIDTH  left operand.
REQ-008 SHALL have port Rbus  input  WIDTH  right operand / shift amount (Rbus[SHW-1:0]).
REQ-009 SHALL have port OP  input  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 SAR, 9 MUL; 10-15 illegal.
REQ-010 SHALL have port Obus  output  WIDTH  registered result, held until the next result.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse marking a new Obus/flags value.
REQ-012 SHALL have port flags  output  4  registered {N,Z,C,V}, updated with Obus.

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid=1 and in_ready=1, capturing Lbus, Rbus, and OP.
REQ-014 SHALL hold in_ready=1 exactly when in state IDLE; states: IDLE, SHIFT, MUL.
REQ-015 SHALL complete ADD, SUB, AND, OR, XOR in 1 cycle: Obus/flags/out_valid valid on the edge after acceptance; state stays IDLE.
REQ-016 SHALL compute SUB as Lbus + ~Rbus + 1, modulo 2^WIDTH.
REQ-017 SHALL perform SHL/SHR/SAR iteratively, 1 bit per cycle, amount n=Rbus[SHW-1:0]; n=0 completes in 1 cycle with Obus=Lbus; n>0 enters SHIFT and asserts out_valid n cycles after acceptance.
REQ-018 SHALL fill SHL and SHR with 0 and SAR with the sign bit.
REQ-019 SHALL perform MUL as unsigned shift-add over WIDTH cycles in state MUL, with out_valid asserted WIDTH cycles after acceptance and Obus = low WIDTH bits of the product.
REQ-020 SHALL set flags as: N=Obus[WIDTH-1]; Z=(Obus==0); C=carry-out for ADD and SUB (C=1 means no borrow), last bit shifted out for shifts with n>0, otherwise 0; V=signed overflow for ADD/SUB, otherwise 0.
REQ-021 SHALL treat NOP and illegal opcodes as accepted, 1-cycle operations with no out_valid and Obus/flags unchanged.
REQ-022 SHALL return to IDLE on the same edge that asserts out_valid, so in_ready=1 in the out_valid cycle and back-to-back acceptance is possible.
REQ-023 SHALL ignore in_valid while in_ready=0 and SHALL NOT queue requests.
REQ-024 SHALL keep out_valid low in every cycle without a completing result.
REQ-025 SHALL ignore operand input changes after acceptance (operands are captured at acceptance).

Reset
REQ-026 SHALL, while res=0, force state=IDLE, Obus=0, flags=4'b0000, out_valid=0, in_ready=0, independent of clk.
REQ-027 SHALL abort any in-flight SHIFT/MUL on reset with no out_valid; in_ready=1 on the first clk edge after res rises.

Verification
REQ-028 SHALL verify (WIDTH=16): ADD 16'hFFFF+16'h0001 -> next cycle Obus=16'h0000, flags N0 Z1 C1 V0, out_valid one cycle.
REQ-029 SHALL verify: SUB 16'h8000-16'h0001 -> Obus=16'h7FFF, N0 Z0 C1 V1; SUB 16'h0000-16'h0001 -> Obus=16'hFFFF, C0.
REQ-030 SHALL verify: SAR Lbus=16'h8004, Rbus=3 -> in_ready low 2 cycles, out_valid 3 cycles after acceptance, Obus=16'hF000, C=1; SHL with Rbus=0 -> 1 cycle, Obus=Lbus, C=0.
REQ-031 SHALL verify: MUL 16'h0123*16'h0010 -> out_valid exactly 16 cycles after acceptance, Obus=16'h1230; in_valid pulses during busy are ignored.
REQ-032 SHALL verify: res=0 asserted mid-MUL (cycle 5) -> outputs immediately 0, no out_valid; new ADD 2+3 after release -> Obus=16'h0005.
REQ-033 SHALL verify: NOP/OP=4'hF after ADD result 16'h0005 -> no out_valid, Obus and flags unchanged; back-to-back ADDs accepted on consecutive edges.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request / result bundle for alu_seq.
//   master: drives in_valid, Lbus, Rbus, OP; observes in_ready, Obus, out_valid, flags.
//   slave : the ALU side (inverse directions).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Lbus;
    logic [WIDTH-1:0] Rbus;
    logic [3:0]       OP;
    logic [WIDTH-1:0] Obus;
    logic             out_valid;
    logic [3:0]       flags;

    modport master (
        output in_valid, Lbus, Rbus, OP,
        input  in_ready, Obus, out_valid, flags
    );

    modport slave (
        input  in_valid, Lbus, Rbus, OP,
        output in_ready, Obus, out_valid, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Logic/arithmetic ops finish in one cycle, shifts take one
// cycle per bit, MUL is a WIDTH-cycle unsigned shift-add.
//   clk : clock, all state changes on its rising edge
//   res : asynchronous active-low reset
//   bus : alu_seq_if.slave -- in_valid/in_ready handshake, Lbus/Rbus/OP operands,
//         Obus/flags registered result ({N,Z,C,V}), out_valid one-cycle result pulse
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      res,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OpAdd = 4'd1;
    localparam logic [3:0] OpSub = 4'd2;
    localparam logic [3:0] OpAnd = 4'd3;
    localparam logic [3:0] OpOr  = 4'd4;
    localparam logic [3:0] OpXor = 4'd5;
    localparam logic [3:0] OpShl = 4'd6;
    localparam logic [3:0] OpShr = 4'd7;
    localparam logic [3:0] OpSar = 4'd8;
    localparam logic [3:0] OpMul = 4'd9;

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // shift value or running product
    logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand, shifted left each step
    logic [WIDTH-1:0] mpl_q, mpl_d;      // multiplier, shifted right each step
    logic [SHW-1:0]   cnt_q, cnt_d;      // steps remaining, result written when 1
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] obus_q, obus_d;
    logic [3:0]       flags_q, flags_d;
    logic             ovalid_q, ovalid_d;
    logic             live_q;            // low until the first edge after reset release

    logic             in_ready_int;
    logic             accept;
    logic             is_shift;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   st_in;
    logic [WIDTH:0]   st_acc;
    logic [WIDTH-1:0] prod;

    // One-bit shift step; returns {bit shifted out, shifted value}.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] v, input logic [3:0] op);
        case (op)
            OpShl:   step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OpShr:   step = {v[0], 1'b0, v[WIDTH-1:1]};
            OpSar:   step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: step = {1'b0, v};
        endcase
    endfunction

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] v, input logic c,
                                            input logic ov);
        mk_flags = {v[WIDTH-1], (v == '0), c, ov};
    endfunction

    assign accept   = bus.in_valid && in_ready_int;
    assign is_shift = (bus.OP == OpShl) || (bus.OP == OpShr) || (bus.OP == OpSar);

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_shift && (bus.Rbus[SHW-1:0] > SHW'(1))) begin
                        state_d = StShift;
                    end else if (bus.OP == OpMul) begin
                        state_d = StMul;
                    end
                end
            end
            StShift, StMul: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mpl_d    = mpl_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        obus_d   = obus_q;
        flags_d  = flags_q;
        ovalid_d = 1'b0;

        // SUB is L + ~R + 1, so C=1 means no borrow.
        b_eff  = (bus.OP == OpSub) ? ~bus.Rbus : bus.Rbus;
        sum    = {1'b0, bus.Lbus} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (bus.OP == OpSub)};
        ovf    = (bus.Lbus[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.Lbus[WIDTH-1]);
        sh_amt = bus.Rbus[SHW-1:0];
        st_in  = step(bus.Lbus, bus.OP);
        st_acc = step(acc_q, op_q);
        prod   = acc_q + (mpl_q[0] ? mcand_q : '0);

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.OP)
                        OpAdd, OpSub: begin
                            obus_d   = sum[WIDTH-1:0];
                            flags_d  = mk_flags(sum[WIDTH-1:0], sum[WIDTH], ovf);
                            ovalid_d = 1'b1;
                        end
                        OpAnd, OpOr, OpXor: begin
                            if (bus.OP == OpAnd) begin
                                obus_d = bus.Lbus & bus.Rbus;
                            end else if (bus.OP == OpOr) begin
                                obus_d = bus.Lbus | bus.Rbus;
                            end else begin
                                obus_d = bus.Lbus ^ bus.Rbus;
                            end
                            flags_d  = mk_flags(obus_d, 1'b0, 1'b0);
                            ovalid_d = 1'b1;
                        end
                        OpShl, OpShr, OpSar: begin
                            if (sh_amt == '0) begin
                                obus_d   = bus.Lbus;
                                flags_d  = mk_flags(bus.Lbus, 1'b0, 1'b0);
                                ovalid_d = 1'b1;
                            end else if (sh_amt == SHW'(1)) begin
                                // Single-bit shift completes on the accepting edge.
                                obus_d   = st_in[WIDTH-1:0];
                                flags_d  = mk_flags(st_in[WIDTH-1:0], st_in[WIDTH], 1'b0);
                                ovalid_d = 1'b1;
                            end else begin
                                // First bit shifts on the accepting edge.
                                acc_d = st_in[WIDTH-1:0];
                                cnt_d = sh_amt - SHW'(1);
                                op_d  = bus.OP;
                            end
                        end
                        OpMul: begin
                            // Multiplier bit 0 is consumed on the accepting edge.
                            acc_d   = bus.Rbus[0] ? bus.Lbus : '0;
                            mcand_d = bus.Lbus << 1;
                            mpl_d   = bus.Rbus >> 1;
                            cnt_d   = SHW'(WIDTH - 1);
                        end
                        default: ;  // NOP and illegal opcodes: accepted, no effect
                    endcase
                end
            end
            StShift: begin
                acc_d = st_acc[WIDTH-1:0];
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    obus_d   = st_acc[WIDTH-1:0];
                    flags_d  = mk_flags(st_acc[WIDTH-1:0], st_acc[WIDTH], 1'b0);
                    ovalid_d = 1'b1;
                end
            end
            StMul: begin
                acc_d   = prod;
                mcand_d = mcand_q << 1;
                mpl_d   = mpl_q >> 1;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    obus_d   = prod;
                    flags_d  = mk_flags(prod, 1'b0, 1'b0);
                    ovalid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mpl_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            obus_q   <= '0;
            flags_q  <= '0;
            ovalid_q <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mpl_q    <= mpl_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            obus_q   <= obus_d;
            flags_q  <= flags_d;
            ovalid_q <= ovalid_d;
            live_q   <= 1'b1;
        end
    end

    // Outputs
    always_comb begin
        in_ready_int  = live_q && (state_q == StIdle);
        bus.in_ready  = in_ready_int;
        bus.Obus      = obus_q;
        bus.flags     = flags_q;
        bus.out_valid = ovalid_q;
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;

    logic clk;
    logic res;
    int   n_checks;
    int   n_fail;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] l, input logic [15:0] r);
        bus.in_valid = 1'b1;
        bus.OP       = op;
        bus.Lbus     = l;
        bus.Rbus     = r;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] o, input logic [3:0] f);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " Obus"}, 32'(bus.Obus), 32'(o));
        check({tag, " flags"}, 32'(bus.flags), 32'(f));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        res          = 1'b0;
        bus.in_valid = 1'b0;
        bus.OP       = 4'd0;
        bus.Lbus     = 16'h0;
        bus.Rbus     = 16'h0;

        // Reset state
        tick();
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst Obus", 32'(bus.Obus), 32'd0);
        check("rst flags", 32'(bus.flags), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        res = 1'b1;
        tick();
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);

        // ADD FFFF+0001 -> 0000, N0 Z1 C1 V0
        drive(4'd1, 16'hFFFF, 16'h0001);
        tick();
        bus.in_valid = 1'b0;
        check_res("add wrap", 16'h0000, 4'b0110);
        tick();
        check("add pulse end", 32'(bus.out_valid), 32'd0);
        check("add hold", 32'(bus.Obus), 32'h0000);

        // Back-to-back SUBs
        drive(4'd2, 16'h8000, 16'h0001);
        tick();
        drive(4'd2, 16'h0000, 16'h0001);
        check_res("sub ovf", 16'h7FFF, 4'b0011);
        tick();
        bus.in_valid = 1'b0;
        check_res("sub borrow", 16'hFFFF, 4'b1000);

        // Logic ops
        drive(4'd3, 16'hF0F0, 16'h0FF0);
        tick();
        check_res("and", 16'h00F0, 4'b0000);
        drive(4'd4, 16'h8000, 16'h0001);
        tick();
        check_res("or", 16'h8001, 4'b1000);
        drive(4'd5, 16'hAAAA, 16'hAAAA);
        tick();
        bus.in_valid = 1'b0;
        check_res("xor", 16'h0000, 4'b0100);

        // SAR 8004 by 3 -> F000, C=1
        drive(4'd8, 16'h8004, 16'h0003);
        tick();
        bus.in_valid = 1'b0;
        bus.Lbus     = 16'h0000;
        check("sar busy1 in_ready", 32'(bus.in_ready), 32'd0);
        check("sar busy1 out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("sar busy2 in_ready", 32'(bus.in_ready), 32'd0);
        check("sar busy2 out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_res("sar", 16'hF000, 4'b1010);
        check("sar done in_ready", 32'(bus.in_ready), 32'd1);

        // SHL by 0 (upper Rbus bits ignored) -> Lbus, C=0
        drive(4'd6, 16'h1234, 16'h0010);
        tick();
        check_res("shl0", 16'h1234, 4'b0000);
        // SHL by 1 -> one cycle, C = old msb
        drive(4'd6, 16'h8001, 16'h0001);
        tick();
        check_res("shl1", 16'h0002, 4'b0010);
        // SHR 0003 by 2 -> 0000, C=1, two cycles
        drive(4'd7, 16'h0003, 16'h0002);
        tick();
        bus.in_valid = 1'b0;
        check("shr busy out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_res("shr2", 16'h0000, 4'b0110);

        // MUL 0123*0010 -> 1230 after 16 cycles; busy requests ignored
        drive(4'd9, 16'h0123, 16'h0010);
        tick();
        for (int i = 1; i <= 14; i++) begin
            bus.in_valid = i[0];
            bus.OP       = 4'd1;
            bus.Lbus     = 16'hFFFF;
            bus.Rbus     = 16'h0001;
            check("mul busy out_valid", 32'(bus.out_valid), 32'd0);
            check("mul busy in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("mul c15 out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check_res("mul", 16'h1230, 4'b0000);
        tick();
        check("mul no queue out_valid", 32'(bus.out_valid), 32'd0);
        check("mul no queue Obus", 32'(bus.Obus), 32'h1230);

        // Reset mid-MUL
        drive(4'd9, 16'h0123, 16'h0010);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        res = 1'b0;
        #1;
        check("async rst Obus", 32'(bus.Obus), 32'd0);
        check("async rst flags", 32'(bus.flags), 32'd0);
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        res = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("abort out_valid", 32'(bus.out_valid), 32'd0);
            check("abort in_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(4'd1, 16'h0002, 16'h0003);
        tick();
        check_res("add after rst", 16'h0005, 4'b0000);

        // NOP and illegal opcode leave the result untouched
        drive(4'd0, 16'hFFFF, 16'hFFFF);
        tick();
        check("nop out_valid", 32'(bus.out_valid), 32'd0);
        check("nop Obus", 32'(bus.Obus), 32'h0005);
        check("nop flags", 32'(bus.flags), 32'd0);
        check("nop in_ready", 32'(bus.in_ready), 32'd1);
        drive(4'hF, 16'h0000, 16'h0000);
        tick();
        check("ill out_valid", 32'(bus.out_valid), 32'd0);
        check("ill Obus", 32'(bus.Obus), 32'h0005);
        check("ill flags", 32'(bus.flags), 32'd0);

        // Back-to-back ADDs on consecutive edges
        drive(4'd1, 16'h0001, 16'h0001);
        tick();
        drive(4'd1, 16'h7FFF, 16'h0001);
        check_res("b2b add1", 16'h0002, 4'b0000);
        tick();
        bus.in_valid = 1'b0;
        check_res("b2b add2", 16'h8000, 4'b1001);
        tick();
        check("b2b end out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
